// File: rtl/key_logic_pkg.sv
// Shared constants and helpers for the key_logic_debounce block.
package key_logic_pkg;

    localparam logic [1:0] MODE_AND     = 2'd0;
    localparam logic [1:0] MODE_OR      = 2'd1;
    localparam logic [1:0] MODE_XOR     = 2'd2;
    localparam logic [1:0] MODE_NOR_TGL = 2'd3;

    localparam int DEB_CNT_50M = 1_000_000;

    // A one-cycle debounce still needs a 1-bit counter to compare against.
    function automatic int cnt_width(input int deb);
        return (deb > 1) ? $clog2(deb) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser + debouncer: active-low pin in, active-high pressed level
// and a one-cycle press pulse out.
module key_debounce
    import key_logic_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_50M,
    parameter int CNT_W   = cnt_width(DEB_CNT)
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic key_down,
    output logic key_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_level_d;
    logic             r_down;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff = r_sync2 != r_stable;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_stable  <= 1'b1;
            r_cnt     <= '0;
            r_level_d <= 1'b0;
            r_down    <= 1'b0;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
            // Any return to the stable level forfeits all accumulated credit.
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= ~r_stable;
            r_down    <= ~r_stable & ~r_level_d;
        end
    end

    assign key_level = ~r_stable;
    assign key_down  = r_down;

endmodule

// File: rtl/key_logic_debounce.sv
// KEY_NUM debounced keys combined by a runtime-selected logic function into a registered LED.
// Define KEY_LOGIC_TOGGLE_EN to turn mode 3 from NOR into a press-driven LED toggle.
module key_logic_debounce
    import key_logic_pkg::*;
#(
    parameter int KEY_NUM = 2,
    parameter int DEB_CNT = DEB_CNT_50M,
    parameter int CNT_W   = cnt_width(DEB_CNT)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key,
    input  logic [1:0]         mode,
    output logic [KEY_NUM-1:0] key_down,
    output logic [KEY_NUM-1:0] key_level,
    output logic               led
);

    logic w_logic;
    logic r_led;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_debounce #(
            .DEB_CNT (DEB_CNT),
            .CNT_W   (CNT_W)
        ) u_deb (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key       (key[i]),
            .key_down  (key_down[i]),
            .key_level (key_level[i])
        );
    end

    always_comb begin
        w_logic = 1'b0;
        case (mode)
            MODE_AND: w_logic = &key_level;
            MODE_OR:  w_logic = |key_level;
            MODE_XOR: w_logic = ^key_level;
            default:  w_logic = ~|key_level;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_led <= 1'b0;
        end else begin
`ifdef KEY_LOGIC_TOGGLE_EN
            // The LED flop doubles as toggle state, so entering mode 3 keeps its value.
            if (mode == MODE_NOR_TGL)
                r_led <= r_led ^ (|key_down);
            else
                r_led <= w_logic;
`else
            r_led <= w_logic;
`endif
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_key_logic_debounce.sv
// Scoreboard bench for key_logic_debounce with KEY_NUM=2, DEB_CNT=4.
module tb_key_logic_debounce;

    localparam int KN  = 2;
    localparam int DEB = 4;
    localparam int LAT = 2 + DEB;   // pin edge to key_level change, in clock edges

    typedef struct {
        logic [1:0] lvl;
        logic [1:0] dn;
        logic       led;
    } exp_t;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [KN-1:0] key;
    logic [1:0]    mode;
    logic [KN-1:0] key_down;
    logic [KN-1:0] key_level;
    logic          led;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    key_logic_debounce #(.KEY_NUM(KN), .DEB_CNT(DEB)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .mode      (mode),
        .key_down  (key_down),
        .key_level (key_level),
        .led       (led)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic void push(input logic [1:0] l, input logic [1:0] d, input logic o);
        exp_t x;
        x.lvl = l; x.dn = d; x.led = o;
        sb.push_back(x);
    endfunction

    // Expected trace for n edges after a held pin change: level at LAT, pulse/led at LAT+1.
    function automatic void push_qual(input int n, input logic [1:0] l0, input logic [1:0] l1,
                                      input logic [1:0] dp, input logic o0, input logic o1);
        for (int k = 1; k <= n; k++)
            push((k >= LAT) ? l1 : l0, (k == LAT + 1) ? dp : 2'b00, (k >= LAT + 1) ? o1 : o0);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        key = 2'b00; mode = 2'd0;
        sys_rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({key_level, key_down, led} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold got lvl/dn/led=%b/%b/%b want 00/00/0", key_level, key_down, led);
        end
        sys_rst_n = 1'b1;
        push_qual(8, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1);
        push_qual(8, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL reset_release edge=%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         k + 1, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
            if (k == 7) key = 2'b11;
        end
    endtask

    task automatic test_bounce();
        mode = 2'd1;
        key  = 2'b10;
        for (int k = 0; k < 12; k++) push(2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL bounce edge=%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         k + 1, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
            if (k == 2) key = 2'b11;
        end
    endtask

    task automatic test_modes();
        logic [3:0] tbl;
        logic       prev;
`ifdef KEY_LOGIC_TOGGLE_EN
        tbl = 4'b1110;   // {mode3..mode0}: toggle keeps led=1 on entry
`else
        tbl = 4'b0110;
`endif
        key = 2'b10;
        push_qual(8, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL press_k0 edge=%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         k + 1, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
        end
        prev = 1'b1;
        for (int m = 0; m < 4; m++) begin
            mode = m[1:0];
            push(2'b01, 2'b00, prev);
            push(2'b01, 2'b00, tbl[m]);
            #3;
            e = sb.pop_front();
            checks++;
            if (led !== e.led) begin
                failures++;
                $display("FAIL mode%0d_pre_edge got led=%b want %b", m, led, e.led);
            end
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL mode%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         m, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
            prev = tbl[m];
        end
    endtask

    task automatic test_press_pulse();
        mode = 2'd0;
        push(2'b01, 2'b00, 1'b0);
        push_qual(8, 2'b01, 2'b11, 2'b10, 1'b0, 1'b1);
        push_qual(8, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 17; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL press_pulse_k1 step=%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         k, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
            if (k == 0) key = 2'b00;
            if (k == 8) key = 2'b10;
        end
    endtask

    task automatic test_reset_mid();
        key = 2'b00;
        for (int k = 0; k < 4; k++) push(2'b01, 2'b00, 1'b0);
        push(2'b00, 2'b00, 1'b0);
        push(2'b00, 2'b00, 1'b0);
        push_qual(8, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL rst_mid_pre edge=%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         k + 1, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
        end
        sys_rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        checks++;
        if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
            failures++;
            $display("FAIL rst_mid_async got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                     key_level, key_down, led, e.lvl, e.dn, e.led);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
            failures++;
            $display("FAIL rst_mid_held got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                     key_level, key_down, led, e.lvl, e.dn, e.led);
        end
        sys_rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL rst_mid_requal edge=%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         k + 1, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
        end
    endtask

    task automatic test_mode3();
        int n;
        key = 2'b11;
        push_qual(8, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
`ifdef KEY_LOGIC_TOGGLE_EN
        push(2'b00, 2'b00, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int k = 1; k <= 10; k++)
                push((k >= LAT) ? 2'b01 : 2'b00, (k == LAT + 1) ? 2'b01 : 2'b00,
                     (k >= LAT + 2) ? ~p[0] : p[0]);
            push_qual(8, 2'b01, 2'b00, 2'b00, ~p[0], ~p[0]);
        end
        n = 9 + 3 * 18;
`else
        push(2'b00, 2'b00, 1'b1);
        push_qual(8, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
        n = 9 + 8;
`endif
        for (int k = 0; k < n; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({key_level, key_down, led} !== {e.lvl, e.dn, e.led}) begin
                failures++;
                $display("FAIL mode3 step=%0d got lvl/dn/led=%b/%b/%b want %b/%b/%b",
                         k, key_level, key_down, led, e.lvl, e.dn, e.led);
            end
            if (k == 7) mode = 2'd3;
            if (k >= 8 && ((k - 8) % 18) == 0) key = 2'b10;
            if (k >= 8 && ((k - 8) % 18) == 10) key = 2'b11;
        end
    endtask

    initial begin
        sys_rst_n = 1'b1;
        key       = 2'b11;
        mode      = 2'd0;
        #2;
        test_reset();
        test_bounce();
        test_modes();
        test_press_pulse();
        test_reset_mid();
        test_mode3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
